// File: rtl/demux_sequencer_pkg.sv
// Shared definitions for the demux sequencer: FSM state encoding, channel
// count/index width and the redirect counter ceiling.
package demux_sequencer_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  localparam logic [7:0] REDIRECT_MAX = 8'd255;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  // Next channel in rotation; wraps 3 -> 0 through the natural 2-bit overflow.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return ch + {{(CH_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/demux_sequencer_onehot_dec2x4.sv
// 2-to-4 one-hot decoder with enable; produces the per-channel valid vector.
// Ports:
//   sel_i    - selected channel index
//   en_i     - high while a word is being held
//   onehot_o - one-hot of sel_i when enabled, all zero otherwise
module demux_sequencer_onehot_dec2x4
  import demux_sequencer_pkg::*;
(
  input  logic [CH_W-1:0]   sel_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_sequencer.sv
// Sequencer for a 1-to-4 demux: captures one upstream word over valid/ready,
// steers it to an addressed or round-robin channel and holds it until that
// channel accepts. Round-robin words stuck on a stalled channel for TIMEOUT
// cycles are redirected to the next channel.
// Ports:
//   Clk, Reset          - clock and synchronous active-high reset
//   InValid/InReady     - upstream handshake, InData the upstream word
//   Mode, Dest          - 0: addressed to Dest, 1: round-robin (sampled at capture)
//   OutValid/OutReady   - per-channel handshake, OutData the held word
//   Sel                 - currently selected channel (demux select)
//   Redirects           - saturating count of timeout redirects
module demux_sequencer
  import demux_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [WIDTH-1:0]  InData,
  input  logic              Mode,
  input  logic [CH_W-1:0]   Dest,
  output logic [NUM_CH-1:0] OutValid,
  input  logic [NUM_CH-1:0] OutReady,
  output logic [WIDTH-1:0]  OutData,
  output logic [CH_W-1:0]   Sel,
  output logic [7:0]        Redirects
);

  localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit             RedirEn = (TIMEOUT != 0);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  wait_q, wait_d;
  logic             mode_q, mode_d;
  logic [7:0]       redir_q, redir_d;

  logic accept;
  logic timeout_hit;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      wait_q   <= '0;
      mode_q   <= 1'b0;
      redir_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      wait_q   <= wait_d;
      mode_q   <= mode_d;
      redir_q  <= redir_d;
    end
  end

  // Only the selected channel's ready matters; the others are ignored.
  assign accept      = OutReady[sel_q];
  assign timeout_hit = RedirEn && mode_q && (wait_q == CntLast);

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    wait_d   = wait_q;
    mode_d   = mode_q;
    redir_d  = redir_q;

    unique case (state_q)
      StIdle: begin
        if (InValid) begin
          data_d  = InData;
          sel_d   = Mode ? rr_ptr_q : Dest;
          mode_d  = Mode;
          wait_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        // Accept has priority over a coincident timeout.
        if (accept) begin
          state_d = StIdle;
          if (mode_q) begin
            rr_ptr_d = next_ch(sel_q);
          end
        end else if (timeout_hit) begin
          sel_d  = next_ch(sel_q);
          wait_d = '0;
          if (redir_q != REDIRECT_MAX) begin
            redir_d = redir_q + 8'd1;
          end
        end else if (mode_q) begin
          wait_d = wait_q + {{(CntW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    InReady   = (state_q == StIdle) && !Reset;
    OutData   = data_q;
    Sel       = sel_q;
    Redirects = redir_q;
  end

  demux_sequencer_onehot_dec2x4 u_dec (
    .sel_i    (sel_q),
    .en_i     (state_q == StHold),
    .onehot_o (OutValid)
  );

endmodule
